// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter (SLL/ROL/SRL/SRA) with valid/ready on both sides.
// Optional macro SHIFTER_PIPE_ROTATE_EN enables rotate-left; otherwise funct 01 behaves as SLL.
module shifter_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int LOG2W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [LOG2W-1:0] N,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] R,
  output logic             R_zero
);

  localparam int B  = (LOG2W + STAGES - 1) / STAGES;
  localparam int CS = (STAGES > 1) ? STAGES - 1 : 1;
  localparam logic [LOG2W-1:0] SLICE_MASK = LOG2W'((1 << B) - 1);

  localparam logic [1:0] F_SLL = 2'b00;
  localparam logic [1:0] F_ROL = 2'b01;
  localparam logic [1:0] F_SRL = 2'b10;
  localparam logic [1:0] F_SRA = 2'b11;

  function automatic logic [WIDTH-1:0] shift_op(input logic [WIDTH-1:0] d,
                                                input logic [1:0]       f,
                                                input logic             sign,
                                                input logic [LOG2W-1:0] amt);
    logic [WIDTH-1:0] res;
    case (f)
      F_SRL: res = d >> amt;
      // sign fill comes from the carried original MSB, not the partial result
      F_SRA: res = (d >> amt) | (sign ? ~({WIDTH{1'b1}} >> amt) : '0);
`ifdef SHIFTER_PIPE_ROTATE_EN
      F_ROL: res = (d << amt) | (d >> ((LOG2W+1)'(WIDTH) - {1'b0, amt}));
`endif
      default: res = d << amt;
    endcase
    return res;
  endfunction

  // per-stage registers; control fields only needed between stages
  logic [STAGES-1:0] v_q;
  logic [WIDTH-1:0]  d_q [STAGES];
  logic [1:0]        f_q [CS];
  logic [CS-1:0]     sg_q;
  logic [LOG2W-1:0]  n_q [CS];
  logic              zr_q;

  logic [STAGES:0]   rdy;
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] sg_in;
  logic [WIDTH-1:0]  d_in [STAGES];
  logic [WIDTH-1:0]  d_sh [STAGES];
  logic [1:0]        f_in [STAGES];
  logic [LOG2W-1:0]  n_in [STAGES];

  always_comb begin
    rdy   = '0;
    v_in  = '0;
    sg_in = '0;
    for (int s = 0; s < STAGES; s++) begin
      d_in[s] = '0;
      d_sh[s] = '0;
      f_in[s] = '0;
      n_in[s] = '0;
    end

    // ready ripples back from the consumer so a full pipe still streams
    rdy[STAGES] = out_ready;
    for (int s = STAGES - 1; s >= 0; s--)
      rdy[s] = !v_q[s] || rdy[s+1];

    v_in[0]  = in_valid;
    d_in[0]  = a;
    f_in[0]  = funct;
    sg_in[0] = a[WIDTH-1];
    n_in[0]  = N;
    for (int s = 1; s < STAGES; s++) begin
      v_in[s]  = v_q[s-1];
      d_in[s]  = d_q[s-1];
      f_in[s]  = f_q[s-1];
      sg_in[s] = sg_q[s-1];
      n_in[s]  = n_q[s-1];
    end

    // remaining N is kept right-aligned, so each stage masks its low slice
    for (int s = 0; s < STAGES; s++)
      d_sh[s] = shift_op(d_in[s], f_in[s], sg_in[s], (n_in[s] & SLICE_MASK) << (s * B));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q  <= '0;
      sg_q <= '0;
      zr_q <= 1'b0;
      for (int s = 0; s < STAGES; s++)
        d_q[s] <= '0;
      for (int s = 0; s < CS; s++) begin
        f_q[s] <= '0;
        n_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (rdy[s]) begin
          v_q[s] <= v_in[s];
          // bubbles leave the data untouched so R stays quiet between results
          if (v_in[s])
            d_q[s] <= d_sh[s];
        end
      end
      for (int s = 0; s < STAGES - 1; s++) begin
        if (rdy[s] && v_in[s]) begin
          f_q[s]  <= f_in[s];
          sg_q[s] <= sg_in[s];
          n_q[s]  <= n_in[s] >> B;
        end
      end
      if (rdy[STAGES-1] && v_in[STAGES-1])
        zr_q <= (d_sh[STAGES-1] == '0);
    end
  end

  assign in_ready  = !reset && rdy[0];
  assign out_valid = v_q[STAGES-1];
  assign R         = d_q[STAGES-1];
  assign R_zero    = zr_q;

endmodule

// File: tb/tb_shifter_pipe.sv
// Testbench for shifter_pipe (WIDTH=32, STAGES=2): directed cases plus randomized
// traffic checked against an arithmetic reference model and an in-order scoreboard.
module tb_shifter_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  funct;
  logic [31:0] a;
  logic [4:0]  N;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] R;
  logic        R_zero;

  int n_chk  = 0;
  int n_fail = 0;
  int n_ret  = 0;
  logic last_acc = 1'b0;
  logic [31:0] exp_q[$];

  shifter_pipe #(.WIDTH(32), .STAGES(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .a(a), .N(N),
    .out_valid(out_valid), .out_ready(out_ready),
    .R(R), .R_zero(R_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_shift(input logic [1:0] f, input logic [31:0] x, input int n);
    logic [31:0] r;
    case (f)
      2'b00: r = x << n;
`ifdef SHIFTER_PIPE_ROTATE_EN
      2'b01: r = (n == 0) ? x : ((x << n) | (x >> (32 - n)));
`else
      2'b01: r = x << n;
`endif
      2'b10: r = x >> n;
      default: r = $signed(x) >>> n;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one clock: bookkeeping at the falling edge, return 1ns after the rising edge
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    last_acc = in_valid && in_ready && !reset;
    if (out_valid && out_ready && !reset) begin
      n_ret++;
      if (exp_q.size() == 0) check("spurious_out_valid", {31'b0, out_valid}, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("sb_R", R, e);
        check("sb_R_zero", {31'b0, R_zero}, {31'b0, (e == 32'd0)});
      end
    end
    if (last_acc) exp_q.push_back(ref_shift(funct, a, int'(N)));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic run_one(input logic [1:0] f, input logic [31:0] x, input logic [4:0] n,
                         input logic [31:0] exp_r);
    funct = f; a = x; N = n; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    check("accepted", {31'b0, last_acc}, 32'd1);
    in_valid = 1'b0;
    funct = 2'($urandom); a = $urandom; N = 5'($urandom);
    #1;
    check("lat1_out_valid", {31'b0, out_valid}, 32'd0);
    tick();
    check("lat2_out_valid", {31'b0, out_valid}, 32'd1);
    check("lat2_R", R, exp_r);
    check("lat2_R_zero", {31'b0, R_zero}, {31'b0, (exp_r == 32'd0)});
    tick();
  endtask

  initial begin
    int t, idx, base;
    logic [31:0] r_hold;
    logic [1:0]  bf[6];
    logic [31:0] ba[6];
    logic [4:0]  bn[6];

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    funct = 2'b00; a = 32'h0; N = 5'd0;
    @(posedge clk); #1;
    tick(); tick();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_R", R, 32'd0);
    check("rst_R_zero", {31'b0, R_zero}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    run_one(2'b00, 32'h0000000A, 5'd1,  32'h00000014);
    run_one(2'b10, 32'h0000000A, 5'd1,  32'h00000005);
    run_one(2'b11, 32'hFFFFFFFB, 5'd1,  32'hFFFFFFFD);
    run_one(2'b11, 32'h00000005, 5'd1,  32'h00000002);
    run_one(2'b11, 32'hFFFFFFFF, 5'd31, 32'hFFFFFFFF);
    run_one(2'b10, 32'h80000000, 5'd31, 32'h00000001);
    for (int f = 0; f < 4; f++) run_one(2'(f), 32'hAABBCCDD, 5'd0, 32'hAABBCCDD);
    run_one(2'b00, 32'h00000001, 5'd31, 32'h80000000);
    run_one(2'b00, 32'h00000002, 5'd31, 32'h00000000);
`ifdef SHIFTER_PIPE_ROTATE_EN
    run_one(2'b01, 32'h80000001, 5'd4, 32'h00000018);
`else
    run_one(2'b01, 32'h80000001, 5'd4, 32'h00000010);
`endif

    // back-pressure: 6 back-to-back ops, consumer stalls for cycles 3..5
    for (int i = 0; i < 6; i++) begin
      bf[i] = 2'($urandom); ba[i] = $urandom; bn[i] = 5'($urandom);
    end
    base = n_ret; idx = 0; t = 0; r_hold = '0;
    while (idx < 6 && t < 30) begin
      in_valid = 1'b1; funct = bf[idx]; a = ba[idx]; N = bn[idx];
      out_ready = !(t >= 3 && t < 6);
      #1;
      if (t >= 3 && t < 6) begin
        check("stall_in_ready", {31'b0, in_ready}, 32'd0);
        check("stall_out_valid", {31'b0, out_valid}, 32'd1);
        if (t == 3) begin
          r_hold = R;
          check("stall_R_head", R, exp_q[0]);
        end else check("stall_R_stable", R, r_hold);
      end
      tick();
      if (last_acc) idx++;
      t++;
    end
    check("bp_all_issued", idx, 32'd6);
    in_valid = 1'b0; out_ready = 1'b1;
    drain(20);
    check("bp_retired", n_ret - base, 32'd6);

    // randomized traffic with input gaps and random back-pressure
    base = n_ret; idx = 0;
    for (int c = 0; c < 200; c++) begin
      if (!in_valid || last_acc) begin
        in_valid = (idx < 60) && ($urandom_range(3) != 0);
        funct = 2'($urandom); a = $urandom; N = 5'($urandom);
      end
      out_ready = ($urandom_range(3) != 0);
      tick();
      if (last_acc) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain(20);
    check("rand_retired", n_ret - base, idx);

    // reset with two operations in flight
    funct = 2'b00; a = 32'h12345678; N = 5'd4; in_valid = 1'b1;
    tick();
    funct = 2'b10; a = 32'hF0F0F0F0; N = 5'd2;
    tick();
    in_valid = 1'b0; out_ready = 1'b0; reset = 1'b1;
    tick();
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_R", R, 32'd0);
    check("midrst_R_zero", {31'b0, R_zero}, 32'd0);
    exp_q.delete();
    reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("post_rst_no_output", {31'b0, out_valid}, 32'd0);
      tick();
    end
    run_one(2'b00, 32'h00000001, 5'd3, 32'h00000008);
    drain(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
